// File: rtl/slot_ctrl_pkg.sv
// Slot-controller state encoding. The top-level FSM controller reuses this encoding for its
// per-slot state, so the values are fixed rather than left to the tools.
package slot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_RUN    = 2'b11
  } slot_state_e;

endpackage : slot_ctrl_pkg

// File: rtl/slot_ap_ctrl_responder_if.sv
// ap-ctrl bundle between the top controller, this slot's responder and its child tasks.
// The slave modport is the responder's view; the master modport is the environment's view.
interface slot_ap_ctrl_responder_if #(
  parameter int NUM_TASKS    = 3,
  parameter int NUM_SCALARS  = 2,
  parameter int SCALAR_WIDTH = 64
);

  logic                                ap_start;
  logic                                ap_ready;
  logic                                ap_done;
  logic                                ap_idle;
  logic [NUM_SCALARS*SCALAR_WIDTH-1:0] scalars_in;
  logic [NUM_SCALARS*SCALAR_WIDTH-1:0] task_scalars;
  logic [NUM_TASKS-1:0]                task_ap_start;
  logic [NUM_TASKS-1:0]                task_ap_ready;
  logic [NUM_TASKS-1:0]                task_ap_done;
  logic [NUM_TASKS-1:0]                task_ap_idle;
  // Debug only: all children report idle; never feeds control.
  logic                                children_idle;

  modport slave (
    input  ap_start, scalars_in, task_ap_ready, task_ap_done, task_ap_idle,
    output ap_ready, ap_done, ap_idle, task_scalars, task_ap_start, children_idle
  );

  modport master (
    output ap_start, scalars_in, task_ap_ready, task_ap_done, task_ap_idle,
    input  ap_ready, ap_done, ap_idle, task_scalars, task_ap_start, children_idle
  );

endinterface : slot_ap_ctrl_responder_if

// File: rtl/task_handshake_tracker.sv
// Sticky per-child handshake bits with synchronous clear. The all_o output also counts
// bits being set this cycle, so the completion decision costs no extra cycle.
module task_handshake_tracker #(
  parameter int NUM_TASKS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [NUM_TASKS-1:0] set_i,
  output logic [NUM_TASKS-1:0] seen_o,
  output logic                 all_o
);

  logic [NUM_TASKS-1:0] seen_q;
  logic [NUM_TASKS-1:0] seen_d;

  always_comb begin
    seen_d = seen_q | set_i;
    if (clr_i) begin
      seen_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen_o = seen_q;
  assign all_o  = &(seen_q | set_i);

endmodule : task_handshake_tracker

// File: rtl/slot_ap_ctrl_responder.sv
// Slot-side ap-ctrl responder: latches scalars on ap_start, launches all child tasks and
// returns one registered ap_ready/ap_done pulse once every child has responded.
module slot_ap_ctrl_responder
  import slot_ctrl_pkg::*;
#(
  parameter int NUM_TASKS    = 3,
  parameter int NUM_SCALARS  = 2,
  parameter int SCALAR_WIDTH = 64
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  slot_ap_ctrl_responder_if.slave  bus
);

  localparam int SW = NUM_SCALARS * SCALAR_WIDTH;

  slot_state_e          state_q;
  slot_state_e          state_d;
  logic                 ap_ready_q;
  logic                 ap_ready_d;
  logic                 ap_done_q;
  logic                 ap_done_d;
  logic [SW-1:0]        task_scalars_q;
  logic [SW-1:0]        task_scalars_d;

  logic [NUM_TASKS-1:0] rdy_seen;
  logic [NUM_TASKS-1:0] done_seen;
  logic [NUM_TASKS-1:0] rdy_set;
  logic [NUM_TASKS-1:0] done_set;
  logic [NUM_TASKS-1:0] task_start;
  logic                 rdy_all;
  logic                 done_all;
  logic                 accept;
  logic                 idle;

  // The registered ap_ready blocks a re-launch while the controller still holds ap_start.
  assign accept   = (state_q == ST_IDLE) && bus.ap_start && !ap_ready_q;
  assign rdy_set  = (state_q == ST_LAUNCH) ? (task_start & bus.task_ap_ready) : '0;
  assign done_set = (state_q != ST_IDLE) ? bus.task_ap_done : '0;

  task_handshake_tracker #(.NUM_TASKS(NUM_TASKS)) u_rdy_tracker (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .clr_i  (accept),
    .set_i  (rdy_set),
    .seen_o (rdy_seen),
    .all_o  (rdy_all)
  );

  task_handshake_tracker #(.NUM_TASKS(NUM_TASKS)) u_done_tracker (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .clr_i  (accept),
    .set_i  (done_set),
    .seen_o (done_seen),
    .all_o  (done_all)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= ST_IDLE;
      ap_ready_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      task_scalars_q <= '0;
    end else begin
      state_q        <= state_d;
      ap_ready_q     <= ap_ready_d;
      ap_done_q      <= ap_done_d;
      task_scalars_q <= task_scalars_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ap_ready_d     = 1'b0;
    ap_done_d      = 1'b0;
    task_scalars_d = task_scalars_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          task_scalars_d = bus.scalars_in;
          state_d        = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Children that finish before all have accepted collapse into one combined pulse.
        if (rdy_all && done_all) begin
          ap_ready_d = 1'b1;
          ap_done_d  = 1'b1;
          state_d    = ST_IDLE;
        end else if (rdy_all) begin
          ap_ready_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done_all) begin
          ap_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    task_start = '0;
    idle       = 1'b0;
    case (state_q)
      ST_IDLE:   idle       = 1'b1;
      ST_LAUNCH: task_start = ~rdy_seen;
      default:   task_start = '0;
    endcase
  end

  assign bus.ap_ready      = ap_ready_q;
  assign bus.ap_done       = ap_done_q;
  assign bus.ap_idle       = idle;
  assign bus.task_scalars  = task_scalars_q;
  assign bus.task_ap_start = task_start;
  assign bus.children_idle = &bus.task_ap_idle;

endmodule : slot_ap_ctrl_responder

// File: tb/tb_slot_ap_ctrl_responder.sv
// Directed bench for slot_ap_ctrl_responder: inputs change 1 time unit after a rising edge,
// outputs are sampled 1 unit later; "cycle n" is the period after the n-th edge past reset.
module tb_slot_ap_ctrl_responder;

  localparam int NT = 3;
  localparam int NS = 2;
  localparam int SW = 64;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  slot_ap_ctrl_responder_if #(.NUM_TASKS(NT), .NUM_SCALARS(NS), .SCALAR_WIDTH(SW)) bus ();

  slot_ap_ctrl_responder #(.NUM_TASKS(NT), .NUM_SCALARS(NS), .SCALAR_WIDTH(SW)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  localparam logic [127:0] SC_A = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
  localparam logic [127:0] SC_B = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
  localparam logic [127:0] SC_D = {64'h0000_0000_0000_00D1, 64'h0000_0000_0000_00D0};
  localparam logic [127:0] SC_E = {64'h0000_0000_0000_00E1, 64'h0000_0000_0000_00E0};
  localparam logic [127:0] SC_F = {64'h0000_0000_0000_00F1, 64'h0000_0000_0000_00F0};
  localparam logic [127:0] SC_G = {64'h0000_0000_0000_0010, 64'h0000_0000_0000_00A5};

  initial begin
    cyc                = 0;
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b0;
    bus.ap_start       = 1'b0;
    bus.scalars_in     = '0;
    bus.task_ap_ready  = '0;
    bus.task_ap_done   = '0;
    bus.task_ap_idle   = '0;

    // Reset state
    #2;
    chk("rst_idle",     bus.ap_idle,       1);
    chk("rst_ready",    bus.ap_ready,      0);
    chk("rst_done",     bus.ap_done,       0);
    chk("rst_start",    bus.task_ap_start, 0);
    chk("rst_scalars",  bus.task_scalars,  0);
    chk("rst_chidle",   bus.children_idle, 0);
    #1 rst_n = 1'b1;

    // Single run: readies at 4/5/7, dones at 20/25/30
    go_to(2);  bus.ap_start = 1'b1; bus.scalars_in = SC_A; #1;
    chk("t1_c2_idle",   bus.ap_idle,       1);
    chk("t1_c2_start",  bus.task_ap_start, 0);
    go_to(3);  bus.scalars_in = SC_B; #1;
    chk("t1_c3_idle",   bus.ap_idle,       0);
    chk("t1_c3_start",  bus.task_ap_start, 3'b111);
    chk("t1_c3_scal",   bus.task_scalars,  SC_A);
    go_to(4);  bus.task_ap_ready = 3'b001; #1;
    chk("t1_c4_start",  bus.task_ap_start, 3'b111);
    go_to(5);  bus.task_ap_ready = 3'b010; #1;
    chk("t1_c5_start",  bus.task_ap_start, 3'b110);
    go_to(6);  bus.task_ap_ready = 3'b000; #1;
    chk("t1_c6_start",  bus.task_ap_start, 3'b100);
    go_to(7);  bus.task_ap_ready = 3'b100; #1;
    chk("t1_c7_start",  bus.task_ap_start, 3'b100);
    chk("t1_c7_ready",  bus.ap_ready,      0);
    go_to(8);  bus.task_ap_ready = 3'b000; #1;
    chk("t1_c8_ready",  bus.ap_ready,      1);
    chk("t1_c8_start",  bus.task_ap_start, 0);
    go_to(9);  bus.ap_start = 1'b0; #1;
    chk("t1_c9_ready",  bus.ap_ready,      0);
    chk("t1_c9_scal",   bus.task_scalars,  SC_A);
    go_to(20); bus.task_ap_done = 3'b001; #1;
    go_to(21); bus.task_ap_done = 3'b000; #1;
    go_to(25); bus.task_ap_done = 3'b010; #1;
    go_to(26); bus.task_ap_done = 3'b000; #1;
    chk("t1_c26_done",  bus.ap_done,       0);
    go_to(30); bus.task_ap_done = 3'b100; #1;
    chk("t1_c30_done",  bus.ap_done,       0);
    chk("t1_c30_idle",  bus.ap_idle,       0);
    go_to(31); bus.task_ap_done = 3'b000; #1;
    chk("t1_c31_done",  bus.ap_done,       1);
    chk("t1_c31_idle",  bus.ap_idle,       1);
    go_to(32); #1;
    chk("t1_c32_done",  bus.ap_done,       0);

    // Combined completion: all ready and done in one cycle
    go_to(40); bus.ap_start = 1'b1; bus.scalars_in = SC_B; #1;
    go_to(42); bus.task_ap_ready = 3'b111; bus.task_ap_done = 3'b111; #1;
    go_to(43); bus.task_ap_ready = 3'b000; bus.task_ap_done = 3'b000; #1;
    chk("t2_c43_ready", bus.ap_ready,      1);
    chk("t2_c43_done",  bus.ap_done,       1);
    chk("t2_c43_idle",  bus.ap_idle,       1);
    go_to(44); bus.ap_start = 1'b0; #1;
    chk("t2_c44_ready", bus.ap_ready,      0);
    chk("t2_c44_done",  bus.ap_done,       0);
    chk("t2_c44_start", bus.task_ap_start, 0);
    chk("t2_c44_idle",  bus.ap_idle,       1);

    // Early done: child 1 finishes before child 0 accepts
    go_to(50); bus.ap_start = 1'b1; #1;
    go_to(52); bus.task_ap_done = 3'b010; #1;
    go_to(53); bus.task_ap_done = 3'b000; #1;
    go_to(54); bus.task_ap_ready = 3'b001; #1;
    go_to(55); bus.task_ap_ready = 3'b110; #1;
    chk("t3_c55_start", bus.task_ap_start, 3'b110);
    go_to(56); bus.task_ap_ready = 3'b000; #1;
    chk("t3_c56_ready", bus.ap_ready,      1);
    chk("t3_c56_done",  bus.ap_done,       0);
    go_to(57); bus.ap_start = 1'b0; #1;
    go_to(60); bus.task_ap_done = 3'b100; #1;
    go_to(61); bus.task_ap_done = 3'b000; #1;
    chk("t3_c61_done",  bus.ap_done,       0);
    chk("t3_c61_idle",  bus.ap_idle,       0);
    go_to(63); bus.task_ap_done = 3'b001; #1;
    go_to(64); bus.task_ap_done = 3'b000; #1;
    chk("t3_c64_done",  bus.ap_done,       1);
    go_to(65); #1;
    chk("t3_c65_done",  bus.ap_done,       0);

    // Idle-time done pulse is ignored; duplicate dones from child 2
    go_to(70); bus.task_ap_done = 3'b010; #1;
    go_to(71); bus.task_ap_done = 3'b000; #1;
    chk("t4_c71_idle",  bus.ap_idle,       1);
    chk("t4_c71_start", bus.task_ap_start, 0);
    go_to(72); bus.ap_start = 1'b1; #1;
    go_to(73); bus.task_ap_ready = 3'b111; bus.task_ap_done = 3'b100; #1;
    chk("t4_c73_start", bus.task_ap_start, 3'b111);
    go_to(74); bus.task_ap_ready = 3'b000; bus.task_ap_done = 3'b000; #1;
    chk("t4_c74_ready", bus.ap_ready,      1);
    chk("t4_c74_done",  bus.ap_done,       0);
    go_to(75); bus.ap_start = 1'b0; bus.task_ap_done = 3'b100; #1;
    go_to(76); bus.task_ap_done = 3'b000; #1;
    go_to(77); bus.task_ap_done = 3'b100; #1;
    go_to(78); bus.task_ap_done = 3'b011; #1;
    chk("t4_c78_done",  bus.ap_done,       0);
    go_to(79); bus.task_ap_done = 3'b000; #1;
    chk("t4_c79_done",  bus.ap_done,       1);
    go_to(80); #1;
    chk("t4_c80_done",  bus.ap_done,       0);
    chk("t4_c80_idle",  bus.ap_idle,       1);

    // Asynchronous reset in the middle of a run
    go_to(90); bus.ap_start = 1'b1; bus.scalars_in = SC_D; bus.task_ap_idle = 3'b111; #1;
    chk("t5_chidle",    bus.children_idle, 1);
    go_to(91); bus.task_ap_ready = 3'b111; #1;
    go_to(92); bus.task_ap_ready = 3'b000; #1;
    chk("t5_c92_ready", bus.ap_ready,      1);
    chk("t5_c92_idle",  bus.ap_idle,       0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", bus.ap_ready,      0);
    chk("t5_rst_done",  bus.ap_done,       0);
    chk("t5_rst_start", bus.task_ap_start, 0);
    chk("t5_rst_idle",  bus.ap_idle,       1);
    chk("t5_rst_scal",  bus.task_scalars,  0);
    bus.ap_start = 1'b0;
    #3 rst_n = 1'b1;
    go_to(93); #1;
    chk("t5_c93_idle",  bus.ap_idle,       1);
    go_to(95); bus.task_ap_done = 3'b111; #1;
    go_to(96); bus.task_ap_done = 3'b000; #1;
    chk("t5_c96_done",  bus.ap_done,       0);
    go_to(97); bus.ap_start = 1'b1; bus.scalars_in = SC_E; #1;
    go_to(98); bus.task_ap_ready = 3'b111; bus.task_ap_done = 3'b111; #1;
    chk("t5_c98_start", bus.task_ap_start, 3'b111);
    chk("t5_c98_scal",  bus.task_scalars,  SC_E);
    go_to(99); bus.task_ap_ready = 3'b000; bus.task_ap_done = 3'b000; #1;
    chk("t5_c99_ready", bus.ap_ready,      1);
    chk("t5_c99_done",  bus.ap_done,       1);
    go_to(100); bus.ap_start = 1'b0; #1;

    // Back-to-back: relaunch right after ap_done with fresh scalars
    go_to(110); bus.ap_start = 1'b1; bus.scalars_in = SC_F; #1;
    go_to(111); bus.task_ap_ready = 3'b111; #1;
    go_to(112); bus.task_ap_ready = 3'b000; #1;
    chk("t6_c112_ready", bus.ap_ready,     1);
    go_to(113); bus.ap_start = 1'b0; bus.task_ap_done = 3'b111; #1;
    go_to(114); bus.task_ap_done = 3'b000; #1;
    chk("t6_c114_done",  bus.ap_done,      1);
    chk("t6_c114_idle",  bus.ap_idle,      1);
    chk("t6_c114_scal",  bus.task_scalars, SC_F);
    go_to(115); bus.ap_start = 1'b1; bus.scalars_in = SC_G; #1;
    chk("t6_c115_idle",  bus.ap_idle,      1);
    go_to(116); #1;
    chk("t6_c116_start", bus.task_ap_start, 3'b111);
    chk("t6_c116_scal",  bus.task_scalars,  SC_G);
    chk("t6_c116_idle",  bus.ap_idle,       0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_slot_ap_ctrl_responder

// File: doc/slot_ap_ctrl_responder.md
Name: slot_ap_ctrl_responder

Overview:
Slot-side end of the top-level ap-ctrl handshake. Sits inside one floorplan slot. It accepts ap_start and the scalar arguments from the top FSM controller, and launches NUM_TASKS child task instances with latched scalars. It tracks each child's ap_ready and ap_done, then returns one aggregated ap_ready/ap_done/ap_idle to the top controller. The top controller holds ap_start high until it samples ap_ready, and it treats ap_ready and ap_done in the same cycle as immediate completion.

Parameters:
NUM_TASKS, 3, number of child tasks in the slot (must be >= 1)
NUM_SCALARS, 2, number of scalar arguments forwarded to children
SCALAR_WIDTH, 64, width of each scalar argument

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset; asynchronous, active-low
ap_start  in  1  start request from the top controller; level, held until ap_ready is sampled
ap_ready  out  1  one-cycle pulse: every child has accepted start
ap_done  out  1  one-cycle pulse: every child has finished
ap_idle  out  1  high when in IDLE
scalars_in  in  NUM_SCALARS*SCALAR_WIDTH  scalar arguments from the top controller
task_scalars  out  NUM_SCALARS*SCALAR_WIDTH  scalars latched at start; stable for the whole run
task_ap_start  out  NUM_TASKS  per-child start
task_ap_ready  in  NUM_TASKS  per-child ready
task_ap_done  in  NUM_TASKS  per-child done
task_ap_idle  in  NUM_TASKS  per-child idle; not used for control; reserved for debug

Behaviour:
- State register: IDLE=2'b00, LAUNCH=2'b01, RUN=2'b11. Sticky vectors: rdy_seen[NUM_TASKS], done_seen[NUM_TASKS].
- Reset (async, ap_rst_n low) clears: state=IDLE, rdy_seen=0, done_seen=0, ap_ready=0, ap_done=0, task_scalars=0.
  - task_ap_start is decoded from state and rdy_seen, so it drops to 0 asynchronously.
  - Reset mid-run abandons the run silently; no ap_done is produced.
- IDLE:
  - ap_idle=1.
  - ap_start is accepted only when the registered ap_ready is 0. This prevents a re-trigger in the cycle where the top controller still holds ap_start after seeing ap_ready.
  - On accept: latch scalars_in into task_scalars, clear rdy_seen and done_seen, move to LAUNCH.
- LAUNCH:
  - task_ap_start[i] = ~rdy_seen[i].
  - rdy_seen[i] sets on task_ap_start[i] & task_ap_ready[i].
  - Define rdy_all = &(rdy_seen | (task_ap_start & task_ap_ready)) and done_all = &(done_seen | task_ap_done).
  - If rdy_all & done_all: next cycle ap_ready=1 and ap_done=1, state=IDLE.
  - Else if rdy_all: next cycle ap_ready=1, state=RUN.
- RUN:
  - task_ap_start=0.
  - When done_all: next cycle ap_done=1, state=IDLE.
- done_seen[i] sets on task_ap_done[i] in LAUNCH or RUN, regardless of whether rdy_seen[i] is set. Done pulses in IDLE are ignored.
- Latency:
  - ap_start sampled at edge k gives task_ap_start high in cycle k+1.
  - Last child ready sampled at edge j gives ap_ready high in cycle j+1 only.
  - Same rule for ap_done relative to the last child done.
- Edge cases:
  - Repeated ready or done pulses from one child are absorbed by the sticky bits.
  - Children may complete in any order.
  - A child may assert ready and done in the same cycle.
- ap_ready and ap_done are registered. ap_done is never asserted in a cycle after ap_ready unless ap_ready was previously pulsed in this run.
- Back-to-back runs: a new ap_start may be accepted in the cycle after the ap_done pulse.

Decomposition:
- Shared package slot_ctrl_pkg:
  - state encoding constants ST_IDLE, ST_LAUNCH, ST_RUN;
  - the 2-bit state typedef, shared with the top controller's slot-state encoding.
- Sub-module task_handshake_tracker:
  - parameterised by NUM_TASKS;
  - one sticky set/clear bit-vector with an "all set including this cycle" output;
  - instantiated twice, for ready and for done.

Test Plan:
- Single run, NUM_TASKS=3: ap_start high at cycle 2; children ready at cycles 4/5/7 and done at 20/25/30 -> task_ap_start bits drop individually; ap_ready pulse at 8; ap_done pulse at 31; ap_idle high again from 31. task_scalars equal scalars_in as sampled at cycle 2, even when scalars_in changes at cycle 3.
- Combined completion: all children ready and done in the same cycle 5 -> ap_ready=ap_done=1 in cycle 6 only; state IDLE at 6; ap_start still high in cycle 6 does not re-launch.
- Early done: child 1 done at cycle 4 before child 0 ready at cycle 6 -> done_seen[1] retained; ap_done fires only after children 0 and 2 are done.
- Duplicate and idle pulses: child 2 pulses done three times, plus task_ap_done while in IDLE -> exactly one ap_done per run; no spurious launch.
- Async reset mid-RUN at a non-clock-aligned time -> task_ap_start, ap_ready and ap_done go 0 immediately; ap_idle=1 after release; the next ap_start runs normally.
- Back-to-back: ap_start re-asserted in the cycle after ap_done -> second launch begins the following cycle with freshly latched scalars 0xA5 / 0x10.
